// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-pointer FIFO and its read-side consumers.
//   DATA_W   : width of a FIFO word
//   PTR_W    : FIFO pointer width (address bits plus one wrap bit)
//   occ_e    : occupancy encoding of the 2-entry output buffer
package fifo_pkg;

    localparam int DATA_W = 8;
    localparam int PTR_W  = 11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry head/skid register pair with an occupancy FSM.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear of both entries (wins over push/pop)
//   push      : push_data is written into the buffer this cycle
//   pop       : head word is consumed this cycle
//   valid     : at least one word held (decoded from the state register)
//   head      : oldest word
//   occ       : current occupancy state
module fifo_skid_buf #(
    parameter int DATA_W = fifo_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [DATA_W-1:0] head,
    output fifo_pkg::occ_e    occ
);
    import fifo_pkg::*;

    occ_e              state_q, state_d;
    logic [DATA_W-1:0] head_q,  head_d;
    logic [DATA_W-1:0] skid_q,  skid_d;

    // State and data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state and data steering; a push+pop keeps occupancy constant.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (clr) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        head_d  = push_data;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_d = push_data;
                    end else if (push) begin
                        skid_d  = push_data;
                        state_d = ST_TWO;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // A push without a pop here would overflow; the issue
                    // logic upstream never lets that happen, so it is ignored.
                    if (push && pop) begin
                        head_d = skid_q;
                        skid_d = push_data;
                    end else if (pop) begin
                        head_d  = skid_q;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    assign valid = (state_q != ST_EMPTY);
    assign head  = head_q;
    assign occ   = state_q;

endmodule

// File: rtl/fifo_fwft_reader.sv
// First-word-fall-through reader for the dual-pointer FIFO (read clock domain).
//   clk_r, rst : read clock, asynchronous active-high reset
//   flush      : synchronous clear of buffered and in-flight words
//   r_en       : FIFO read enable (combinational)
//   empty      : FIFO empty flag, synchronised to clk_r
//   data_out   : FIFO read data, valid the cycle after r_en
//   m_valid, m_data, m_ready : valid/ready output stream
//   rd_count   : completed stream transfers, wraps, not cleared by flush
module fifo_fwft_reader #(
    parameter int DATA_W = fifo_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk_r,
    input  logic              rst,
    input  logic              flush,
    output logic              r_en,
    input  logic              empty,
    input  logic [DATA_W-1:0] data_out,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  rd_count
);
    import fifo_pkg::*;

    logic             inflight_q, inflight_d;
    logic             discard_q,  discard_d;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;

    logic             pop_s;
    logic             ret_s;
    logic             push_s;
    logic [2:0]       level_s;
    occ_e             occ_s;

    assign pop_s  = m_valid && m_ready;
    assign ret_s  = inflight_q;
    // Words returning during or right after a flush belong to reads issued
    // before the flush and must not reach the buffer.
    assign push_s = ret_s && !discard_q && !flush;

    // Words held plus words on their way, minus the one leaving this cycle.
    // pop implies occupancy >= 1, so the subtraction never underflows.
    assign level_s = {1'b0, occ_s} + {2'b00, inflight_q} - {2'b00, pop_s};

    assign r_en = !empty && !flush && !rst && (level_s < 3'd2);

    fifo_skid_buf #(.DATA_W(DATA_W)) u_buf (
        .clk       (clk_r),
        .rst       (rst),
        .clr       (flush),
        .push      (push_s),
        .push_data (data_out),
        .pop       (pop_s),
        .valid     (m_valid),
        .head      (m_data),
        .occ       (occ_s)
    );

    // Read-tracking and transfer-counter registers.
    always_ff @(posedge clk_r or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
            rd_count_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            rd_count_q <= rd_count_d;
        end
    end

    // Next values for read tracking; a pop during flush still counts.
    always_comb begin
        inflight_d = r_en;
        discard_d  = flush;
        if (pop_s) begin
            rd_count_d = rd_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            rd_count_d = rd_count_q;
        end
    end

    assign rd_count = rd_count_q;

endmodule
